// File: rtl/uart_sched_pkg.sv
// Shared definitions for the uart_tx_sched transmitter scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        COMPLETE  = 3'd4
    } sched_state_e;

    // Width of the shared launch/frame watchdog timer
    localparam int TIMER_W = 16;

    // Default watchdog limits in clk cycles
    localparam int DEF_START_TIMEOUT = 256;
    localparam int DEF_FRAME_TIMEOUT = 2048;

    // Index width for n clients, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin pick: first set request after the pointer, wrapping.
module uart_rr_arb
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_req_o,
    output logic [IDX_W-1:0]   winner_o
);

    logic [IDX_W:0] cand_s;
    logic           found_s;

    assign any_req_o = |req_i;

    // Walk the clients starting just after the pointer; the first hit wins
    always_comb begin
        found_s  = 1'b0;
        winner_o = ptr_i;
        cand_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s   = {1'b0, ptr_i} + (IDX_W+1)'(k);
            cand_s   = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? (cand_s - (IDX_W+1)'(NUM_REQ)) : cand_s;
            winner_o = (!found_s && req_i[cand_s[IDX_W-1:0]]) ? cand_s[IDX_W-1:0] : winner_o;
            found_s  = found_s | req_i[cand_s[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uarttx among NUM_REQ byte-producing clients.
// Sequences the newd/donetx handshake and watchdogs both the launch and the frame.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int FRAME_TIMEOUT = DEF_FRAME_TIMEOUT,
    localparam int IDX_W        = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        done,
    output logic                      tx_newd,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_line,
    input  logic                      tx_done,
    output logic                      busy,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      timeout_err
);

    sched_state_e        state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [TIMER_W-1:0]  timer_q, timer_d, timer_inc_s;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                tx_newd_q, tx_newd_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                timeout_err_q, timeout_err_d;

    logic                line_meta_q, line_sync_q;
    logic                done_meta_q, done_sync_q, done_prev_q;
    logic [1:0]          settle_q;
    logic                done_rise_s;

    logic                any_req_s;
    logic [IDX_W-1:0]    winner_s;
    logic [DATA_W-1:0]   win_byte_s;

    uart_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .any_req_o (any_req_s),
        .winner_o  (winner_s)
    );

    // Synchronise the line monitor and donetx; settle_q blocks grants until the
    // synchroniser holds a real line sample rather than its reset value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_meta_q <= 1'b1;
            line_sync_q <= 1'b1;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            done_prev_q <= 1'b0;
            settle_q    <= 2'b00;
        end else begin
            line_meta_q <= tx_line;
            line_sync_q <= line_meta_q;
            done_meta_q <= tx_done;
            done_sync_q <= done_meta_q;
            done_prev_q <= done_sync_q;
            settle_q    <= {settle_q[0], 1'b1};
        end
    end

    assign done_rise_s = done_sync_q & ~done_prev_q;
    assign timer_inc_s = (timer_q == {TIMER_W{1'b1}}) ? timer_q : (timer_q + TIMER_W'(1));

    // Select the winning client's byte
    always_comb begin
        win_byte_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_byte_s = (winner_s == IDX_W'(i)) ? req_data[i*DATA_W +: DATA_W] : win_byte_s;
        end
    end

    // Next-state and output logic; every output is registered from its _d value
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ack_d         = '0;
        done_d        = '0;
        tx_newd_d     = tx_newd_q;
        tx_data_d     = tx_data_q;
        busy_d        = busy_q;
        grant_id_d    = grant_id_q;
        timeout_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Never grant while the line is low: a frame may still be in flight
                if (any_req_s && line_sync_q && settle_q[1]) begin
                    state_d = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: begin
                // A request dropped before ack simply falls back to IDLE
                if (any_req_s) begin
                    tx_data_d       = win_byte_s;
                    grant_id_d      = winner_s;
                    ack_d[winner_s] = 1'b1;
                    busy_d          = 1'b1;
                    tx_newd_d       = 1'b1;
                    state_d         = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                // Drop newd once the start bit is seen so uarttx does not relaunch
                if (!line_sync_q) begin
                    tx_newd_d = 1'b0;
                    state_d   = WAIT_DONE;
                end else if (timer_q >= TIMER_W'(START_TIMEOUT - 1)) begin
                    tx_newd_d     = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = COMPLETE;
                end else begin
                    state_d = LAUNCH;
                end
            end
            WAIT_DONE: begin
                if (done_rise_s) begin
                    state_d = COMPLETE;
                end else if (timer_q >= TIMER_W'(FRAME_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = COMPLETE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            COMPLETE: begin
                done_d[grant_id_q] = 1'b1;
                ptr_d              = grant_id_q;
                busy_d             = 1'b0;
                state_d            = IDLE;
            end
            default: begin
                tx_newd_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // The watchdog restarts on every state entry
        timer_d = (state_d != state_q) ? '0 : timer_inc_s;
    end

    // State, pointer, timer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            timer_q       <= '0;
            ack_q         <= '0;
            done_q        <= '0;
            tx_newd_q     <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
            ack_q         <= ack_d;
            done_q        <= done_d;
            tx_newd_q     <= tx_newd_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign tx_newd     = tx_newd_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one `uarttx` transmitter among NUM_REQ byte-producing clients.
- Arbitrates client requests and latches the winner's byte onto the transmitter's `newd`/`tx_data` inputs.
- Sequences the transmitter's newd/donetx handshake across its divided baud clock, and returns per-client ack and done pulses.
- Sits between client logic and `uarttx` inside `uart_top`-level integrations.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- DATA_W, 8, byte width; must match the transmitter.
- START_TIMEOUT, 256, clk cycles allowed between newd assertion and start bit seen on the line.
- FRAME_TIMEOUT, 2048, clk cycles allowed between start bit and donetx.

Ports:
- clk  in  1  system clock, the same clk that feeds `uarttx`.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-client request level; held with data stable until ack.
- req_data  in  NUM_REQ*DATA_W  client bytes; client i occupies bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-clk pulse when the client's byte is latched.
- done  out  NUM_REQ  one-clk pulse when the client's frame completes or is aborted.
- tx_newd  out  1  to `uarttx` newd.
- tx_data  out  DATA_W  to `uarttx` tx_data; held stable while tx_newd=1.
- tx_line  in  1  monitor of `uarttx` tx output.
- tx_done  in  1  `uarttx` donetx.
- busy  out  1  high from grant through the completion cycle.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted client.
- timeout_err  out  1  one-clk pulse on either timeout.

Behaviour:
- Reset (rst=0, async) drives:
  - ack, done, tx_newd, busy, timeout_err = 0; tx_data = 0; grant_id = 0.
  - state = IDLE; rr pointer = NUM_REQ-1, so client 0 has first priority.
  - sync flops: tx_line = 1, tx_done = 0.
- Reset taken mid-frame drops tx_newd at once; the scheduler does not re-issue the frame.
- Input synchronisation: tx_line and tx_done pass through 2-flop synchronisers. tx_done is rising-edge detected on the synchronised value.
- States:
  - IDLE: if any req is set and synced tx_line=1, go to ARB. Never grant while the line is low (covers frames in flight after reset).
  - ARB (1 cycle):
    - Winner = first set req searching from pointer+1, wrapping.
    - Latch winner's byte into tx_data, set grant_id, pulse ack[winner], set busy, set tx_newd, clear timer, go to LAUNCH.
  - LAUNCH: hold tx_newd until synced tx_line=0 (start bit), then drop tx_newd, clear timer, go to WAIT_DONE.
    - Dropping tx_newd here is mandatory, so the transmitter does not restart on return to idle.
    - If the timer reaches START_TIMEOUT: drop tx_newd, pulse timeout_err, go to COMPLETE.
  - WAIT_DONE: on the tx_done rising edge go to COMPLETE. If the timer reaches FRAME_TIMEOUT: pulse timeout_err, go to COMPLETE.
  - COMPLETE (1 cycle): pulse done[grant_id], set pointer = grant_id, clear busy, go to IDLE.
- Latency: ack occurs 2 clks after req is sampled in IDLE.
- Back-to-back grants: no new grant until COMPLETE has been passed and the line reads idle.
- Arbitration and request rules:
  - Simultaneous requests are served strictly round-robin; a client holding req is served within NUM_REQ frames.
  - Dropping req before ack withdraws the request with no side effects. req changes after ack are ignored until COMPLETE.
  - A req asserted in the COMPLETE cycle is considered in the next IDLE.
- Timer: 16-bit saturating counter. It is shared across LAUNCH and WAIT_DONE and cleared on every state entry.
- Width rule: grant_id is sized $clog2(NUM_REQ), with a minimum width of 1.

Decomposition:
- Package uart_sched_pkg holds:
  - state encoding: IDLE=0, ARB=1, LAUNCH=2, WAIT_DONE=3, COMPLETE=4; 3-bit.
  - timer width constant; default timeout constants.
- Sub-module uart_rr_arb: combinational round-robin pick. Inputs req and pointer; outputs any_req and winner index.
- The FSM, synchronisers and timer stay in uart_tx_sched.

Test Plan:
- Single request: client 2 sends byte 8'hA5, with `uarttx` at clk_freq=1000000, baud_rate=9600 → one ack[2]; tx_newd drops within 3 clks of the line going low; line carries LSB-first 1,0,1,0,0,1,0,1; done[2] after the donetx edge; busy low afterwards.
- All four requesting at once, bytes 11/22/33/44 → serviced order 0,1,2,3; then client 0 re-requests alongside client 3 → client 0 is served first (pointer=3 wraps).
- Stuck transmitter (tx_line held 1) → tx_newd drops after 256 clks, timeout_err pulses, done[i] pulses, next requester is granted.
- tx_done never asserted after start bit → timeout_err at 2048 clks, done pulses, FSM returns to IDLE.
- Reset asserted mid-WAIT_DONE → tx_newd=0 and busy=0 immediately; a pending request is not granted until synced tx_line has returned to 1.
- req[1] pulsed for one clk while client 0 is busy → no ack[1], no done[1]; scheduler returns to IDLE.
